dsp_mac_tap_sequencer: RTL and testbench

Drives the 20x18 signed feedback-mode DSP MAC block as a 4-tap dot-product engine and collects its result. Accepts a frame of TAPS signed samples on a valid/ready stream and sequences the DSP control inputs per tap. Captures the accumulated product P and presents it on a valid/ready output stream. Sits between the sample source and the DSP primitive; the DSP's clk/reset are shared with this block.

---
 rtl/dsp_mac_tap_sequencer.sv | 159 +++++++++++++++
 tb/tb_dsp_mac_tap_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_tap_sequencer.sv
// rtl/dsp_mac_tap_sequencer.sv - 4-tap dot-product sequencer driving a feedback-mode DSP MAC
module dsp_mac_tap_sequencer #(
    parameter int A_W  = 20,
    parameter int B_W  = 18,
    parameter int P_W  = 38,
    parameter int TAPS = 4,
    parameter int LAT  = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_addr,
    input  logic [A_W-1:0] cfg_data,
    output logic           cfg_drop,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [B_W-1:0] s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [P_W-1:0] m_data,
    output logic [A_W-1:0] dsp_a,
    output logic [B_W-1:0] dsp_b,
    output logic [2:0]     dsp_feedback,
    output logic [3:0]     dsp_acc_fir,
    output logic           dsp_subtract,
    output logic [A_W-1:0] dsp_coef0,
    output logic [A_W-1:0] dsp_coef1,
    output logic [A_W-1:0] dsp_coef2,
    output logic [A_W-1:0] dsp_coef3,
    input  logic [P_W-1:0] dsp_p
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Feedback code 4 loads P with coef0*B (accumulator clear); code 0 accumulates A*B.
    localparam logic [2:0] FB_LOAD  = 3'd4;
    localparam logic [2:0] FB_ACCUM = 3'd0;

    localparam int               WAIT_W   = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [WAIT_W-1:0] LAT_CNT  = WAIT_W'(LAT);
    localparam logic [1:0]       LAST_TAP = 2'(TAPS - 1);

    state_t            state_q, state_d;
    logic [1:0]        tap_q, tap_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [A_W-1:0]    coef_q [TAPS];
    logic [A_W-1:0]    coef_d [TAPS];
    logic              drop_q, drop_d;
    logic              m_valid_q, m_valid_d;
    logic [P_W-1:0]    m_data_q, m_data_d;
    logic [A_W-1:0]    dsp_a_q, dsp_a_d;
    logic [B_W-1:0]    dsp_b_q, dsp_b_d;
    logic [2:0]        fb_q, fb_d;

    assign s_ready      = (state_q == ST_IDLE) || (state_q == ST_TAP);
    assign cfg_drop     = drop_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign dsp_a        = dsp_a_q;
    assign dsp_b        = dsp_b_q;
    assign dsp_feedback = fb_q;
    assign dsp_acc_fir  = 4'd0;
    assign dsp_subtract = 1'b0;
    assign dsp_coef0    = coef_q[0];
    assign dsp_coef1    = coef_q[1];
    assign dsp_coef2    = coef_q[2];
    assign dsp_coef3    = coef_q[3];

    // Next-state logic: per-tap DSP drive, neutral drive on every non-handshake cycle.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        wait_d    = wait_q;
        coef_d    = coef_q;
        drop_d    = drop_q | (cfg_we && (state_q != ST_IDLE));
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        dsp_a_d   = '0;
        dsp_b_d   = '0;
        fb_d      = FB_ACCUM;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    coef_d[cfg_addr] = cfg_data;
                end
                if (s_valid) begin
                    fb_d    = FB_LOAD;
                    dsp_b_d = s_data;
                    tap_d   = 2'd1;
                    state_d = ST_TAP;
                end
            end
            ST_TAP: begin
                if (s_valid) begin
                    dsp_a_d = coef_q[tap_q];
                    dsp_b_d = s_data;
                    if (tap_q == LAST_TAP) begin
                        tap_d   = 2'd0;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end else begin
                        tap_d = tap_q + 2'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == LAT_CNT) begin
                    m_data_d  = dsp_p;
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tap_q     <= 2'd0;
            wait_q    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
            drop_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            dsp_a_q   <= '0;
            dsp_b_q   <= '0;
            fb_q      <= 3'd0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            wait_q    <= wait_d;
            coef_q    <= coef_d;
            drop_q    <= drop_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            dsp_a_q   <= dsp_a_d;
            dsp_b_q   <= dsp_b_d;
            fb_q      <= fb_d;
        end
    end

endmodule

// File: tb/tb_dsp_mac_tap_sequencer.sv
// tb/tb_dsp_mac_tap_sequencer.sv - directed self-checking bench for dsp_mac_tap_sequencer
module tb_dsp_mac_tap_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [19:0] cfg_data;
    logic        cfg_drop;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [37:0] m_data;
    logic [19:0] dsp_a;
    logic [17:0] dsp_b;
    logic [2:0]  dsp_feedback;
    logic [3:0]  dsp_acc_fir;
    logic        dsp_subtract;
    logic [19:0] dsp_coef0, dsp_coef1, dsp_coef2, dsp_coef3;
    logic signed [37:0] dsp_p;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dsp_mac_tap_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_drop     (cfg_drop),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_feedback (dsp_feedback),
        .dsp_acc_fir  (dsp_acc_fir),
        .dsp_subtract (dsp_subtract),
        .dsp_coef0    (dsp_coef0),
        .dsp_coef1    (dsp_coef1),
        .dsp_coef2    (dsp_coef2),
        .dsp_coef3    (dsp_coef3),
        .dsp_p        (dsp_p)
    );

    // Behavioural DSP with one-cycle P latency.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dsp_p <= '0;
        end else if (dsp_feedback == 3'd4) begin
            dsp_p <= $signed(dsp_coef0) * $signed(dsp_b);
        end else if (dsp_feedback == 3'd0) begin
            dsp_p <= dsp_p + $signed(dsp_a) * $signed(dsp_b);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_coefs(input logic [19:0] c0, input logic [19:0] c1,
                               input logic [19:0] c2, input logic [19:0] c3);
        logic [19:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 2'(i);
            cfg_data = c[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Sends four samples, optional bubbles after tap bub_after, optional cfg write
    // alongside tap cfg_at; returns cycles from last accept to m_valid (-1 on timeout).
    task automatic run_frame(input logic [17:0] x0, input logic [17:0] x1,
                             input logic [17:0] x2, input logic [17:0] x3,
                             input int bub_after, input int nbub, input int cfg_at,
                             output int lat);
        logic [17:0] x [4];
        x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_we  = 1'b0;
            s_valid = 1'b1;
            s_data  = x[k];
            if (k == cfg_at) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'd2;
                cfg_data = 20'd100;
            end
            if (k == bub_after) begin
                for (int b = 0; b < nbub; b++) begin
                    @(negedge clk);
                    cfg_we  = 1'b0;
                    s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                    check("bubble_dsp_a", 64'(dsp_a), 64'd0);
                    check("bubble_fb", 64'(dsp_feedback), 64'd0);
                end
            end
        end
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                s_valid = 1'b0;
                cfg_we  = 1'b0;
            end
            if (m_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("m_valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          lat;
        logic [37:0] e;
        reset    = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_dsp_a", 64'(dsp_a), 64'd0);
        check("rst_dsp_b", 64'(dsp_b), 64'd0);
        check("rst_fb", 64'(dsp_feedback), 64'd0);
        check("rst_cfg_drop", 64'(cfg_drop), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_coef0", 64'(dsp_coef0), 64'd0);
        reset = 1'b0;

        // Frame 1: coefs 1,2,3,4, all-ones samples
        write_coefs(20'd1, 20'd2, 20'd3, 20'd4);
        check("coef3", 64'(dsp_coef3), 64'd4);
        run_frame(18'd1, 18'd1, 18'd1, 18'd1, -1, 0, -1, lat);
        check("t1_latency", 64'(lat), 64'd2);
        check("t1_result", 64'(m_data), 64'd10);
        check("t1_s_ready_out", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("t1_m_valid_clr", 64'(m_valid), 64'd0);
        check("t1_idle_ready", 64'(s_ready), 64'd1);

        // Frame 2: mixed signs including max positive sample
        write_coefs(20'd5, -20'sd3, 20'd7, -20'sd1);
        e = -38'sd131093;
        run_frame(-18'sd2, 18'd4, 18'd0, 18'd131071, -1, 0, -1, lat);
        check("t2_result", {26'b0, m_data}, {26'b0, e});
        @(negedge clk);

        // Frame 3: same with three bubbles between taps 1 and 2
        run_frame(-18'sd2, 18'd4, 18'd0, 18'd131071, 1, 3, -1, lat);
        check("t3_result", {26'b0, m_data}, {26'b0, e});
        @(negedge clk);

        // Frame 4: output backpressure for five cycles
        m_ready = 1'b0;
        run_frame(18'd1, 18'd1, 18'd1, 18'd1, -1, 0, -1, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_m_data", 64'(m_data), 64'd8);
            check("bp_m_valid", 64'(m_valid), 64'd1);
            check("bp_s_ready", 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        check("bp_final_data", 64'(m_data), 64'd8);
        @(negedge clk);
        check("bp_released", 64'(m_valid), 64'd0);
        run_frame(18'd2, 18'd0, 18'd0, 18'd0, -1, 0, -1, lat);
        check("bp_next_frame", 64'(m_data), 64'd10);
        @(negedge clk);

        // Frame 5: coefficient write during TAP is dropped
        run_frame(18'd1, 18'd1, 18'd1, 18'd1, -1, 0, 1, lat);
        check("drop_result", 64'(m_data), 64'd8);
        check("drop_flag", 64'(cfg_drop), 64'd1);
        check("drop_coef2", 64'(dsp_coef2), 64'd7);
        @(negedge clk);

        // Reset after two taps
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 18'd3;
        @(negedge clk);
        s_data  = 18'd3;
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b1;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_data", 64'(m_data), 64'd0);
        check("mid_rst_dsp_a", 64'(dsp_a), 64'd0);
        check("mid_rst_dsp_b", 64'(dsp_b), 64'd0);
        check("mid_rst_fb", 64'(dsp_feedback), 64'd0);
        check("mid_rst_cfg_drop", 64'(cfg_drop), 64'd0);
        check("mid_rst_coef1", 64'(dsp_coef1), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        write_coefs(20'd1, 20'd2, 20'd3, 20'd4);
        run_frame(18'd2, 18'd2, 18'd2, 18'd2, -1, 0, -1, lat);
        check("post_rst_result", 64'(m_data), 64'd20);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
